// File: rtl/instruction_issuer.sv
// Per-thread issue stage: buffers instructions, issues them one at a time over the router's
// start/finished port protocol and queues returned results for the consumer.
module instruction_issuer #(
    parameter int unsigned CMD_DEPTH         = 4,
    parameter int unsigned RES_DEPTH         = 4,
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned RESULT_WIDTH      = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] in_instruction,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [RESULT_WIDTH-1:0]      out_result,
    output logic [INSTRUCTION_WIDTH-1:0] port_instruction,
    output logic                         port_start,
    input  logic [RESULT_WIDTH-1:0]      port_result,
    input  logic                         port_finished,
    output logic                         busy,
    output logic [15:0]                  completed
);

    localparam int unsigned CMD_AW = $clog2(CMD_DEPTH);
    localparam int unsigned CMD_CW = CMD_AW + 1;
    localparam int unsigned RES_AW = $clog2(RES_DEPTH);
    localparam int unsigned RES_CW = RES_AW + 1;

    localparam logic [CMD_CW-1:0] CMD_FULL = CMD_CW'(CMD_DEPTH);
    localparam logic [RES_CW-1:0] RES_FULL = RES_CW'(RES_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitFirst,
        StWait
    } state_e;

    state_e state_q, state_d;

    logic [INSTRUCTION_WIDTH-1:0] cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0]            cmd_wr_ptr_q, cmd_rd_ptr_q;
    logic [CMD_CW-1:0]            cmd_count_q, cmd_count_d;

    logic [RESULT_WIDTH-1:0]      res_mem [RES_DEPTH];
    logic [RES_AW-1:0]            res_wr_ptr_q, res_rd_ptr_q;
    logic [RES_CW-1:0]            res_count_q, res_count_d;

    logic [INSTRUCTION_WIDTH-1:0] port_instruction_q;
    logic                         port_start_q;
    logic [15:0]                  completed_q;

    logic cmd_push, res_pop;
    logic issue, capture;

    // Handshakes come from registered counts only; no same-cycle bypass.
    assign in_ready  = (cmd_count_q != CMD_FULL);
    assign out_valid = (res_count_q != '0);
    assign cmd_push  = in_valid & in_ready;
    assign res_pop   = out_valid & out_ready;

    assign out_result       = out_valid ? res_mem[res_rd_ptr_q] : '0;
    assign port_instruction = port_instruction_q;
    assign port_start       = port_start_q;
    assign completed        = completed_q;
    assign busy             = (state_q == StIssue) || (state_q == StWaitFirst) ||
                              (state_q == StWait);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Issue only with a free result slot, so capture can never overflow.
                if ((cmd_count_q != '0) && port_finished && (res_count_q != RES_FULL)) begin
                    issue   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue:     state_d = StWaitFirst;
            // The router still shows finished during this cycle; ignore it.
            StWaitFirst: state_d = StWait;
            StWait: begin
                if (port_finished) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end
            end
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_count_d = cmd_count_q;
        if (cmd_push && !issue) begin
            cmd_count_d = cmd_count_q + CMD_CW'(1);
        end else if (!cmd_push && issue) begin
            cmd_count_d = cmd_count_q - CMD_CW'(1);
        end
    end

    always_comb begin
        res_count_d = res_count_q;
        if (capture && !res_pop) begin
            res_count_d = res_count_q + RES_CW'(1);
        end else if (!capture && res_pop) begin
            res_count_d = res_count_q - RES_CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= StIdle;
            cmd_wr_ptr_q       <= '0;
            cmd_rd_ptr_q       <= '0;
            cmd_count_q        <= '0;
            res_wr_ptr_q       <= '0;
            res_rd_ptr_q       <= '0;
            res_count_q        <= '0;
            port_instruction_q <= '0;
            port_start_q       <= 1'b0;
            completed_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            cmd_count_q  <= cmd_count_d;
            res_count_q  <= res_count_d;
            port_start_q <= issue;
            if (cmd_push) begin
                cmd_wr_ptr_q <= cmd_wr_ptr_q + CMD_AW'(1);
            end
            if (issue) begin
                port_instruction_q <= cmd_mem[cmd_rd_ptr_q];
                cmd_rd_ptr_q       <= cmd_rd_ptr_q + CMD_AW'(1);
            end
            if (capture) begin
                res_wr_ptr_q <= res_wr_ptr_q + RES_AW'(1);
                completed_q  <= completed_q + 16'd1;
            end
            if (res_pop) begin
                res_rd_ptr_q <= res_rd_ptr_q + RES_AW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && cmd_push) begin
            cmd_mem[cmd_wr_ptr_q] <= in_instruction;
        end
        if (!reset && capture) begin
            res_mem[res_wr_ptr_q] <= port_result;
        end
    end

endmodule

// File: doc/instruction_issuer.md
# instruction_issuer

Per-thread issue stage that sits directly upstream of one port of the datapath router. It buffers instructions from a thread's producer in a command FIFO and issues them one at a time over the router's start/finished port protocol. It captures each returned result into a result FIFO for the consumer. Exactly one instruction is in flight per issuer; one issuer is instantiated per router port.

## Interface
- `CMD_DEPTH`, 4, command FIFO entries; power of two, ≥2
- `RES_DEPTH`, 4, result FIFO entries; power of two, ≥2
- Widths `INSTRUCTION_WIDTH` and `RESULT_WIDTH` come from constants.h
- `clock` in 1: single clock; all logic on posedge
- `reset` in 1: synchronous, active-high
- `in_valid` in 1: producer offers `in_instruction`
- `in_ready` out 1: command FIFO not full
- `in_instruction` in `INSTRUCTION_WIDTH`: instruction to issue
- `out_valid` out 1: result FIFO not empty
- `out_ready` in 1: consumer accepts `out_result`
- `out_result` out `RESULT_WIDTH`: head of result FIFO
- `port_instruction` out `INSTRUCTION_WIDTH`: to router port, registered
- `port_start` out 1: to router port, registered one-cycle pulse
- `port_result` in `RESULT_WIDTH`: from router port
- `port_finished` in 1: from router port; high = port idle/result valid
- `busy` out 1: high in ISSUE or WAIT
- `completed` out 16: count of results captured, wraps at 0xFFFF→0

## Operation
- Push: `in_valid & in_ready` at an edge writes `in_instruction` into the command FIFO.
- Pop: `out_valid & out_ready` at an edge removes the head of the result FIFO.
- `in_ready` is `!cmd_full` and `out_valid` is `!res_empty`, both from registered counts. There is no combinational bypass: a full FIFO refuses a push even if it pops in the same cycle.
- FSM states:
  - IDLE → ISSUE when cmd not empty, `port_finished`=1, and `res_count < RES_DEPTH`, all sampled at the same edge.
    - On that edge: pop command head into `port_instruction`, set `port_start`=1.
  - ISSUE (lasts exactly 1 cycle, `port_start`=1) → WAIT. `port_start` clears on this edge.
  - WAIT: `port_finished` is ignored during the first WAIT cycle, because the router lowers it one edge after sampling start.
    - From the second WAIT cycle onward, `port_finished`=1 at an edge → push `port_result` into the result FIFO, increment `completed`, go to IDLE.
- `port_instruction` holds its value from issue until the next issue, so it stays stable for the router's whole transaction.
- The result FIFO always has space at capture, because issue reserves a slot. A consumer pop in the capture cycle is allowed; count arithmetic handles push and pop in the same cycle.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_result`=0
  - `port_instruction`=0, `port_start`=0, `busy`=0, `completed`=0
  - state IDLE, both FIFOs empty
- Push at edge t → earliest issue at edge t+1 → `port_start` high in cycle t+1..t+2.
- Router `finished` rising at edge c (observed high at c) → result pushed at edge c. `out_valid` is high from cycle after c.
- Issue throughput: at most one instruction per 1 (IDLE) + 1 (ISSUE) + router-latency cycles.
- Reset mid-transaction: the FSM returns to IDLE and FIFO contents are dropped.
  - A late router result is discarded because IDLE ignores `port_finished` rising.
  - The next issue waits until `port_finished`=1, so the router is never double-started.
- Result FIFO full: the FSM stays in IDLE with `busy`=0, commands stay queued, and `in_ready` follows command occupancy.

## Test plan
- Single instruction 0x1234 pushed; router model returns 0xBEEF 5 cycles after start → `port_start` high for exactly one cycle with `port_instruction`=0x1234; `out_result`=0xBEEF; `completed`=1.
- Push CMD_DEPTH+1 instructions back-to-back with the router stalled → `in_ready` low after 4 accepted. Results emerge in push order.
- Consumer holds `out_ready`=0 for 6 transactions → exactly RES_DEPTH (4) issued. The 5th issues one cycle after the first pop.
- Router holds `port_finished`=0 at issue time (busy from another port) → no `port_start` until it rises. The instruction then issues.
- Assert `reset` one cycle while in WAIT, then the router returns a result → result dropped, `out_valid`=0, `completed`=0. The next push issues only after `port_finished`=1.
- Pop and capture on the same edge with the result FIFO holding 1 entry → count stays 1 and `out_result` is the new value.
